// File: rtl/soc_addr_map_pkg.sv
// +----------------------------------------------------------------------------+
// | soc_addr_map_pkg : rule record and config word offsets for soc_addr_map     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package soc_addr_map_pkg;

    // Widest supported fields; instances keep only AddrWidth / IdxWidth bits.
    typedef struct packed {
        logic [63:0] base;
        logic [63:0] length;
        logic [15:0] idx;
        logic        en;
        logic        lock;
    } rule_cfg_t;

    localparam logic [1:0] OFFS_BASE   = 2'd0;
    localparam logic [1:0] OFFS_LENGTH = 2'd1;
    localparam logic [1:0] OFFS_IDX    = 2'd2;
    localparam logic [1:0] OFFS_CTRL   = 2'd3;

    // Offsets relative to the first word past the rule table (4*NumRules).
    localparam int DEF_IDX_WORD   = 0;
    localparam int MISS_CNT_WORD  = 1;
    localparam int MISS_ADDR_WORD = 2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/soc_addr_map_match.sv
// +----------------------------------------------------------------------------+
// | soc_addr_map_match : single-rule range comparator, base <= addr < base+len  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module soc_addr_map_match
    import soc_addr_map_pkg::*;
#(
    parameter int AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] length_i,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 match_o
);

    // One extra bit so a region ending exactly at the top of the space cannot wrap.
    logic [AddrWidth:0] w_end;
    logic               w_ge_base;
    logic               w_lt_end;

    assign w_end     = {1'b0, base_i} + {1'b0, length_i};
    assign w_ge_base = (addr_i >= base_i);
    assign w_lt_end  = ({1'b0, addr_i} < w_end);
    assign match_o   = en_i && (length_i != '0) && w_ge_base && w_lt_end;

endmodule

`default_nettype wire

// File: rtl/soc_addr_map_cfg.sv
// +----------------------------------------------------------------------------+
// | soc_addr_map_cfg : programmable, lockable SoC address decoder with a        |
// | 1-stage lookup pipeline. Optional miss logging: ADDR_MAP_MISS_LOG_EN.       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module soc_addr_map_cfg
    import soc_addr_map_pkg::*;
#(
    parameter int                         NumRules  = 16,
    parameter int                         AddrWidth = 64,
    parameter int                         IdxWidth  = 5,
    parameter rule_cfg_t [NumRules-1:0]   RstRules  = '0,
    parameter logic [IdxWidth-1:0]        RstDefIdx = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [63:0]          cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [63:0]          cfg_rdata_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 lkp_valid_o,
    input  logic                 lkp_ready_i,
    output logic                 lkp_hit_o,
    output logic [IdxWidth-1:0]  lkp_idx_o
);

    localparam int         TABLE_WORDS    = 4 * NumRules;
    localparam logic [8:0] DEF_WORD_ADDR  = 9'(TABLE_WORDS + DEF_IDX_WORD);
    localparam logic [8:0] CNT_WORD_ADDR  = 9'(TABLE_WORDS + MISS_CNT_WORD);
    localparam logic [8:0] MADDR_WORD_ADDR = 9'(TABLE_WORDS + MISS_ADDR_WORD);

    logic [AddrWidth-1:0] base_q   [NumRules];
    logic [AddrWidth-1:0] base_d   [NumRules];
    logic [AddrWidth-1:0] length_q [NumRules];
    logic [AddrWidth-1:0] length_d [NumRules];
    logic [IdxWidth-1:0]  idx_q    [NumRules];
    logic [IdxWidth-1:0]  idx_d    [NumRules];
    logic [NumRules-1:0]  en_q, en_d;
    logic [NumRules-1:0]  lock_q, lock_d;
    logic [IdxWidth-1:0]  def_idx_q, def_idx_d;

    logic                 cfg_rvalid_q;
    logic [63:0]          cfg_rdata_q;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d;
    logic [IdxWidth-1:0]  res_idx_q, res_idx_d;

    logic [8:0]           w_cfg_addr;
    logic                 w_is_rule;
    logic [5:0]           w_rule_sel;
    logic [1:0]           w_word_sel;
    logic                 w_wr;
    logic                 w_rd;
    logic [63:0]          w_rdata;
    logic [NumRules-1:0]  w_match;
    logic                 w_hit;
    logic [IdxWidth-1:0]  w_idx;
    logic                 w_accept;

    assign w_cfg_addr = {1'b0, cfg_addr_i};
    assign w_is_rule  = (w_cfg_addr < 9'(TABLE_WORDS));
    assign w_rule_sel = cfg_addr_i[7:2];
    assign w_word_sel = cfg_addr_i[1:0];
    assign w_wr       = cfg_req_i && cfg_we_i;
    assign w_rd       = cfg_req_i && !cfg_we_i;

    // Rule table writes; locked rules silently drop writes but are still acked.
    always_comb begin
        base_d    = base_q;
        length_d  = length_q;
        idx_d     = idx_q;
        en_d      = en_q;
        lock_d    = lock_q;
        def_idx_d = def_idx_q;
        if (w_wr && w_is_rule) begin
            for (int r = 0; r < NumRules; r++) begin
                if (w_rule_sel == 6'(r) && !lock_q[r]) begin
                    case (w_word_sel)
                        OFFS_BASE:   base_d[r]   = cfg_wdata_i[AddrWidth-1:0];
                        OFFS_LENGTH: length_d[r] = cfg_wdata_i[AddrWidth-1:0];
                        OFFS_IDX:    idx_d[r]    = cfg_wdata_i[IdxWidth-1:0];
                        OFFS_CTRL: begin
                            en_d[r]   = cfg_wdata_i[CTRL_EN_BIT];
                            lock_d[r] = cfg_wdata_i[CTRL_LOCK_BIT];
                        end
                        default: ;
                    endcase
                end
            end
        end
        if (w_wr && (w_cfg_addr == DEF_WORD_ADDR)) begin
            def_idx_d = cfg_wdata_i[IdxWidth-1:0];
        end
    end

`ifdef ADDR_MAP_MISS_LOG_EN
    logic [31:0]          miss_cnt_q, miss_cnt_d;
    logic [AddrWidth-1:0] miss_addr_q, miss_addr_d;
    logic                 miss_vld_q, miss_vld_d;
    logic                 w_miss;
    logic                 w_clr;

    assign w_miss = w_accept && !w_hit;
    assign w_clr  = w_wr && ((w_cfg_addr == CNT_WORD_ADDR) || (w_cfg_addr == MADDR_WORD_ADDR));

    // A miss in the same cycle as a clear restarts the log with that miss.
    always_comb begin
        miss_cnt_d  = miss_cnt_q;
        miss_addr_d = miss_addr_q;
        miss_vld_d  = miss_vld_q;
        if (w_clr) begin
            miss_cnt_d  = '0;
            miss_addr_d = '0;
            miss_vld_d  = 1'b0;
        end
        if (w_miss) begin
            if (w_clr || !miss_vld_q) begin
                miss_addr_d = lkp_addr_i;
                miss_vld_d  = 1'b1;
            end
            if (w_clr) begin
                miss_cnt_d = 32'd1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q  <= '0;
            miss_addr_q <= '0;
            miss_vld_q  <= 1'b0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            miss_addr_q <= miss_addr_d;
            miss_vld_q  <= miss_vld_d;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_is_rule) begin
                for (int r = 0; r < NumRules; r++) begin
                    if (w_rule_sel == 6'(r)) begin
                        case (w_word_sel)
                            OFFS_BASE:   w_rdata[AddrWidth-1:0] = base_q[r];
                            OFFS_LENGTH: w_rdata[AddrWidth-1:0] = length_q[r];
                            OFFS_IDX:    w_rdata[IdxWidth-1:0]  = idx_q[r];
                            OFFS_CTRL: begin
                                w_rdata[CTRL_EN_BIT]   = en_q[r];
                                w_rdata[CTRL_LOCK_BIT] = lock_q[r];
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (w_cfg_addr == DEF_WORD_ADDR) begin
                w_rdata[IdxWidth-1:0] = def_idx_q;
            end
`ifdef ADDR_MAP_MISS_LOG_EN
            else if (w_cfg_addr == CNT_WORD_ADDR) begin
                w_rdata[31:0] = miss_cnt_q;
            end else if (w_cfg_addr == MADDR_WORD_ADDR) begin
                w_rdata[AddrWidth-1:0] = miss_addr_q;
                if (AddrWidth < 64) begin
                    w_rdata[63] = miss_vld_q;
                end
            end
`endif
        end
    end

    for (genvar r = 0; r < NumRules; r++) begin : g_rule
        soc_addr_map_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .base_i   (base_q[r]),
            .length_i (length_q[r]),
            .en_i     (en_q[r]),
            .addr_i   (lkp_addr_i),
            .match_o  (w_match[r])
        );
    end

    // Scan from the top so the lowest matching rule is the last assignment.
    always_comb begin
        w_hit = 1'b0;
        w_idx = def_idx_q;
        for (int r = NumRules - 1; r >= 0; r--) begin
            if (w_match[r]) begin
                w_hit = 1'b1;
                w_idx = idx_q[r];
            end
        end
    end

    assign lkp_ready_o = !res_valid_q || lkp_ready_i;
    assign w_accept    = lkp_valid_i && lkp_ready_o;

    always_comb begin
        res_valid_d = res_valid_q;
        res_hit_d   = res_hit_q;
        res_idx_d   = res_idx_q;
        if (w_accept) begin
            res_valid_d = 1'b1;
            res_hit_d   = w_hit;
            res_idx_d   = w_idx;
        end else if (lkp_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NumRules; r++) begin
                base_q[r]   <= RstRules[r].base[AddrWidth-1:0];
                length_q[r] <= RstRules[r].length[AddrWidth-1:0];
                idx_q[r]    <= RstRules[r].idx[IdxWidth-1:0];
                en_q[r]     <= RstRules[r].en;
                lock_q[r]   <= RstRules[r].lock;
            end
            def_idx_q    <= RstDefIdx;
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            res_valid_q  <= 1'b0;
            res_hit_q    <= 1'b0;
            res_idx_q    <= '0;
        end else begin
            base_q       <= base_d;
            length_q     <= length_d;
            idx_q        <= idx_d;
            en_q         <= en_d;
            lock_q       <= lock_d;
            def_idx_q    <= def_idx_d;
            cfg_rvalid_q <= cfg_req_i;
            cfg_rdata_q  <= w_rdata;
            res_valid_q  <= res_valid_d;
            res_hit_q    <= res_hit_d;
            res_idx_q    <= res_idx_d;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign lkp_valid_o  = res_valid_q;
    assign lkp_hit_o    = res_hit_q;
    assign lkp_idx_o    = res_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_addr_map_cfg.sv
// +----------------------------------------------------------------------------+
// | tb_soc_addr_map_cfg : directed scoreboard bench for soc_addr_map_cfg        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_soc_addr_map_cfg;
    import soc_addr_map_pkg::*;

    localparam int NR = 16;
    localparam int AW = 64;
    localparam int IW = 5;

    typedef rule_cfg_t [NR-1:0] tb_rules_t;

    function automatic tb_rules_t mk_rules();
        tb_rules_t r;
        r           = '0;
        r[0].length = 64'h1000;
        r[0].en     = 1'b1;
        r[5].base   = 64'h8000_0000;
        r[5].length = 64'h2000_0000;
        r[5].idx    = 16'd13;
        r[5].en     = 1'b1;
        return r;
    endfunction

    localparam tb_rules_t      TB_RULES   = mk_rules();
    localparam logic [IW-1:0]  TB_DEF_IDX = 5'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_req_i = 1'b0;
    logic          cfg_we_i = 1'b0;
    logic [7:0]    cfg_addr_i = '0;
    logic [63:0]   cfg_wdata_i = '0;
    logic          cfg_rvalid_o;
    logic [63:0]   cfg_rdata_o;
    logic          lkp_valid_i = 1'b0;
    logic          lkp_ready_o;
    logic [AW-1:0] lkp_addr_i = '0;
    logic          lkp_valid_o;
    logic          lkp_ready_i = 1'b1;
    logic          lkp_hit_o;
    logic [IW-1:0] lkp_idx_o;

    soc_addr_map_cfg #(
        .NumRules  (NR),
        .AddrWidth (AW),
        .IdxWidth  (IW),
        .RstRules  (TB_RULES),
        .RstDefIdx (TB_DEF_IDX)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_req_i    (cfg_req_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rvalid_o (cfg_rvalid_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .lkp_valid_i  (lkp_valid_i),
        .lkp_ready_o  (lkp_ready_o),
        .lkp_addr_i   (lkp_addr_i),
        .lkp_valid_o  (lkp_valid_o),
        .lkp_ready_i  (lkp_ready_i),
        .lkp_hit_o    (lkp_hit_o),
        .lkp_idx_o    (lkp_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    endtask

    // Result monitor: one scoreboard entry retires per completed handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && lkp_valid_o && lkp_ready_i) begin
            if (sb_q.size() == 0) begin
                check("lkp_unexpected_result", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                check("lkp_hit", 64'(lkp_hit_o), 64'(e.hit));
                check("lkp_idx", 64'(lkp_idx_o), 64'(e.idx));
            end
        end
    end

    task automatic push_exp(input logic h, input logic [IW-1:0] i);
        exp_t e;
        e.hit = h;
        e.idx = i;
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic lkp_issue(input logic [63:0] a, input logic h, input logic [IW-1:0] i);
        int k;
        lkp_valid_i = 1'b1;
        lkp_addr_i  = a;
        push_exp(h, i);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (lkp_ready_o) break;
            k++;
        end
        if (k >= 20) check("lkp_accept_timeout", 64'(k), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic lkp_idle();
        lkp_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [63:0] d);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        @(posedge clk);
        #1;
        cfg_req_i = 1'b0;
        cfg_we_i  = 1'b0;
    endtask

    task automatic cfg_rd(input string tag, input logic [7:0] a, input logic [63:0] exp);
        cfg_req_i  = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = a;
        @(posedge clk);
        #1;
        cfg_req_i = 1'b0;
        check(tag, cfg_rdata_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset values
        #1;
        check("rst_lkp_valid", 64'(lkp_valid_o), 64'd0);
        check("rst_lkp_ready", 64'(lkp_ready_o), 64'd1);
        check("rst_lkp_hit", 64'(lkp_hit_o), 64'd0);
        check("rst_lkp_idx", 64'(lkp_idx_o), 64'd0);
        check("rst_cfg_rvalid", 64'(cfg_rvalid_o), 64'd0);
        check("rst_cfg_rdata", cfg_rdata_o, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset map contents
        cfg_rd("rd_rule0_len", 8'd1, 64'h1000);
        check("cfg_rvalid_rd", 64'(cfg_rvalid_o), 64'd1);
        cfg_rd("rd_rule5_base", 8'd20, 64'h8000_0000);
        cfg_rd("rd_rule5_idx", 8'd22, 64'd13);
        cfg_rd("rd_rule5_ctrl", 8'd23, 64'd1);
        cfg_rd("rd_def_idx", 8'd64, 64'd7);

        // Reset-map lookups, with one explicit latency check
        lkp_issue(64'h8000_0010, 1'b1, 5'd13);
        check("lkp_latency", 64'(lkp_valid_o), 64'd1);
        lkp_issue(64'h7FFF_FFFC, 1'b0, 5'd7);
        lkp_issue(64'h0000_0FFF, 1'b1, 5'd0);
        lkp_issue(64'h0000_1000, 1'b0, 5'd7);
        lkp_idle();

        // Overlapping regions: lowest rule wins
        cfg_wr(8'd4, 64'h1000_0000);
        check("cfg_wr_ack", 64'(cfg_rvalid_o), 64'd1);
        check("cfg_wr_rdata", cfg_rdata_o, 64'd0);
        cfg_wr(8'd5, 64'h40_0000);
        cfg_wr(8'd6, 64'd4);
        cfg_wr(8'd7, 64'd1);
        cfg_wr(8'd8, 64'h1000_0000);
        cfg_wr(8'd9, 64'h10_0000);
        cfg_wr(8'd10, 64'd11);
        cfg_wr(8'd11, 64'd1);
        lkp_issue(64'h1000_0100, 1'b1, 5'd4);
        lkp_idle();
        cfg_wr(8'd7, 64'd0);
        lkp_issue(64'h1000_0100, 1'b1, 5'd11);
        lkp_issue(64'h1010_0000, 1'b0, 5'd7);
        lkp_idle();

        // Lock on rule 3
        cfg_wr(8'd15, 64'h3);
        cfg_wr(8'd12, 64'h1234);
        cfg_rd("lock_base_kept", 8'd12, 64'd0);
        cfg_wr(8'd15, 64'h0);
        cfg_rd("lock_ctrl_kept", 8'd15, 64'h3);

        // Zero-length rule never hits
        cfg_wr(8'd16, 64'h2000_0000);
        cfg_wr(8'd18, 64'd9);
        cfg_wr(8'd19, 64'd1);
        lkp_issue(64'h2000_0000, 1'b0, 5'd7);
        lkp_idle();

        // Region ending at the top of the address space
        cfg_wr(8'd24, 64'hFFFF_FFFF_FFFF_F000);
        cfg_wr(8'd25, 64'h1000);
        cfg_wr(8'd26, 64'd21);
        cfg_wr(8'd27, 64'd1);
        lkp_issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd21);
        lkp_issue(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 5'd7);
        lkp_idle();

        // Write and lookup in the same cycle: lookup sees the old table
        cfg_wr(8'd28, 64'h3000_0000);
        cfg_wr(8'd29, 64'h100);
        cfg_wr(8'd30, 64'd17);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = 8'd31;
        cfg_wdata_i = 64'd1;
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 64'h3000_0010;
        push_exp(1'b0, 5'd7);
        @(posedge clk);
        #1;
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        lkp_valid_i = 1'b0;
        lkp_issue(64'h3000_0010, 1'b1, 5'd17);
        lkp_idle();

        // Default index and unmapped words
        cfg_wr(8'd64, 64'd3);
        cfg_rd("rd_def_idx_new", 8'd64, 64'd3);
        cfg_wr(8'd67, 64'hDEAD_BEEF);
        cfg_rd("rd_unmapped", 8'd67, 64'd0);

        // Backpressure: A held for 5 cycles while B waits
        lkp_ready_i = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 64'h8000_0010;
        push_exp(1'b1, 5'd13);
        @(posedge clk);
        #1;
        lkp_addr_i = 64'h1000_0100;
        push_exp(1'b1, 5'd11);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 64'(lkp_valid_o), 64'd1);
            check("bp_ready_o", 64'(lkp_ready_o), 64'd0);
            check("bp_hit_stable", 64'(lkp_hit_o), 64'd1);
            check("bp_idx_stable", 64'(lkp_idx_o), 64'd13);
        end
        @(posedge clk);
        #1;
        lkp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_release", 64'(lkp_ready_o), 64'd1);
        @(posedge clk);
        #1;
        lkp_addr_i = 64'h0000_0010;
        push_exp(1'b1, 5'd0);
        @(negedge clk);
        check("stream_valid", 64'(lkp_valid_o), 64'd1);
        check("stream_ready", 64'(lkp_ready_o), 64'd1);
        @(posedge clk);
        #1;
        lkp_addr_i = 64'h6000_0000;
        push_exp(1'b0, 5'd3);
        @(posedge clk);
        #1;
        lkp_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Miss log
        cfg_wr(8'd65, 64'd0);
        lkp_issue(64'h5000_0000, 1'b0, 5'd3);
        lkp_issue(64'h5000_1000, 1'b0, 5'd3);
        lkp_issue(64'h5000_2000, 1'b0, 5'd3);
        lkp_idle();
`ifdef ADDR_MAP_MISS_LOG_EN
        cfg_rd("miss_cnt", 8'd65, 64'd3);
        cfg_rd("miss_addr", 8'd66, 64'h5000_0000);
        cfg_wr(8'd66, 64'd0);
        cfg_rd("miss_cnt_clr", 8'd65, 64'd0);
        cfg_rd("miss_addr_clr", 8'd66, 64'd0);
`else
        cfg_rd("miss_cnt_off", 8'd65, 64'd0);
        cfg_rd("miss_addr_off", 8'd66, 64'd0);
`endif

        // Reset with a result in flight
        lkp_ready_i = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 64'h8000_0010;
        @(posedge clk);
        #1;
        lkp_valid_i = 1'b0;
        check("inflight_valid", 64'(lkp_valid_o), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(lkp_valid_o), 64'd0);
        check("async_rst_ready", 64'(lkp_ready_o), 64'd1);
        lkp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_rd("rst_lock_cleared", 8'd15, 64'd0);
        cfg_rd("rst_rule1_base", 8'd4, 64'd0);
        cfg_rd("rst_def_idx", 8'd64, 64'd7);
        lkp_issue(64'h1000_0100, 1'b0, 5'd7);
        lkp_idle();

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("sb_push_pop", 64'(n_pop), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
